// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: bundle of the inter-stage pipeline register's bus signals.
// The master side (upstream stage / hazard unit) drives the *_i slot plus
// stall/flush and observes the registered slot; the slave side (the register)
// does the reverse.
//   stall, flush        hold / bubble control
//   *_i                 incoming slot: valid, ir, pc, rt, ao, md, a2, a3,
//                       tnew, wd_sel, exc_code, bd, exc_new, exc_code_new
//   valid..bd           registered slot, wd = pre-selected forwarding value
//   wd_rdy              combinational: forwarding value usable now
interface pipe_stage_reg_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5,
    parameter int unsigned TW = 3,
    parameter int unsigned EW = 5
);
    // control
    logic          stall;
    logic          flush;
    // incoming slot
    logic          valid_i;
    logic [DW-1:0] ir_i;
    logic [DW-1:0] pc_i;
    logic [DW-1:0] rt_i;
    logic [DW-1:0] ao_i;
    logic [DW-1:0] md_i;
    logic [RW-1:0] a2_i;
    logic [RW-1:0] a3_i;
    logic [TW-1:0] tnew_i;
    logic [1:0]    wd_sel_i;
    logic [EW-1:0] exc_code_i;
    logic          bd_i;
    logic          exc_new_i;
    logic [EW-1:0] exc_code_new_i;
    // registered slot
    logic          valid;
    logic [DW-1:0] ir;
    logic [DW-1:0] pc;
    logic [DW-1:0] rt;
    logic [DW-1:0] ao;
    logic [DW-1:0] md;
    logic [DW-1:0] wd;
    logic [RW-1:0] a2;
    logic [RW-1:0] a3;
    logic [TW-1:0] tnew;
    logic [EW-1:0] exc_code;
    logic          bd;
    logic          wd_rdy;

    modport master (
        output stall, flush,
        output valid_i, ir_i, pc_i, rt_i, ao_i, md_i, a2_i, a3_i, tnew_i,
        output wd_sel_i, exc_code_i, bd_i, exc_new_i, exc_code_new_i,
        input  valid, ir, pc, rt, ao, md, wd, a2, a3, tnew, exc_code, bd,
        input  wd_rdy
    );

    modport slave (
        input  stall, flush,
        input  valid_i, ir_i, pc_i, rt_i, ao_i, md_i, a2_i, a3_i, tnew_i,
        input  wd_sel_i, exc_code_i, bd_i, exc_new_i, exc_code_new_i,
        output valid, ir, pc, rt, ao, md, wd, a2, a3, tnew, exc_code, bd,
        output wd_rdy
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register (E->M, M->W).
// Carries instruction, PC, operands, hazard fields (a2/a3/tnew) and a
// pre-selected forwarding value wd. Supports stall (hold), flush (bubble),
// exception-code merging with writeback suppression, and branch-delay flag.
//   clk   rising-edge clock
//   rst   synchronous active-high reset (highest priority)
//   bus   pipe_stage_reg_if.slave: stall/flush, incoming *_i slot,
//         registered slot outputs, combinational wd_rdy
module pipe_stage_reg #(
    parameter int unsigned DW      = 32,
    parameter int unsigned RW      = 5,
    parameter int unsigned TW      = 3,
    parameter int unsigned EW      = 5,
    parameter int unsigned PC_OFF  = 8,
    parameter bit          KEEP_PC = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    pipe_stage_reg_if.slave    bus
);

    localparam logic [1:0] WD_AO   = 2'd0;
    localparam logic [1:0] WD_MD   = 2'd1;
    localparam logic [1:0] WD_PC   = 2'd2;

    logic          valid_q;
    logic [DW-1:0] ir_q;
    logic [DW-1:0] pc_q;
    logic [DW-1:0] rt_q;
    logic [DW-1:0] ao_q;
    logic [DW-1:0] md_q;
    logic [DW-1:0] wd_q;
    logic [RW-1:0] a2_q;
    logic [RW-1:0] a3_q;
    logic [TW-1:0] tnew_q;
    logic [EW-1:0] exc_q;
    logic          bd_q;

    logic [EW-1:0] exc_merged_c;
    logic          exc_any_c;
    logic [DW-1:0] wd_sel_c;
    logic [TW-1:0] tnew_dec_c;

    // Load-path next values: merged exception, forwarding mux, tnew countdown
    always_comb begin
        exc_merged_c = bus.exc_code_i;
        if (bus.exc_code_i == '0) begin
            // an exception from an earlier stage takes precedence
            exc_merged_c = bus.exc_new_i ? bus.exc_code_new_i : '0;
        end
        exc_any_c = (exc_merged_c != '0);

        case (bus.wd_sel_i)
            WD_AO:   wd_sel_c = bus.ao_i;
            WD_MD:   wd_sel_c = bus.md_i;
            WD_PC:   wd_sel_c = bus.pc_i + DW'(PC_OFF);
            default: wd_sel_c = '0;
        endcase

        // saturating decrement: a ready result stays ready
        tnew_dec_c = (bus.tnew_i != '0) ? bus.tnew_i - TW'(1) : '0;
    end

    // Slot register: rst > flush > stall > load
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ir_q    <= '0;
            pc_q    <= '0;
            rt_q    <= '0;
            ao_q    <= '0;
            md_q    <= '0;
            wd_q    <= '0;
            a2_q    <= '0;
            a3_q    <= '0;
            tnew_q  <= '0;
            exc_q   <= '0;
            bd_q    <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
            ir_q    <= '0;
            rt_q    <= '0;
            ao_q    <= '0;
            md_q    <= '0;
            wd_q    <= '0;
            a2_q    <= '0;
            a3_q    <= '0;
            tnew_q  <= '0;
            exc_q   <= '0;
            // bubble may keep PC/BD so a later exception still has an EPC
            pc_q    <= KEEP_PC ? bus.pc_i : '0;
            bd_q    <= KEEP_PC ? bus.bd_i : 1'b0;
        end else if (!bus.stall) begin
            valid_q <= bus.valid_i;
            ir_q    <= bus.ir_i;
            pc_q    <= bus.pc_i;
            rt_q    <= bus.rt_i;
            ao_q    <= bus.ao_i;
            md_q    <= bus.md_i;
            a2_q    <= bus.a2_i;
            bd_q    <= bus.bd_i;
            exc_q   <= exc_merged_c;
            // an excepting instruction must neither write back nor forward
            a3_q    <= exc_any_c ? '0 : bus.a3_i;
            tnew_q  <= exc_any_c ? '0 : tnew_dec_c;
            wd_q    <= exc_any_c ? '0 : wd_sel_c;
        end
    end

    assign bus.valid    = valid_q;
    assign bus.ir       = ir_q;
    assign bus.pc       = pc_q;
    assign bus.rt       = rt_q;
    assign bus.ao       = ao_q;
    assign bus.md       = md_q;
    assign bus.wd       = wd_q;
    assign bus.a2       = a2_q;
    assign bus.a3       = a3_q;
    assign bus.tnew     = tnew_q;
    assign bus.exc_code = exc_q;
    assign bus.bd       = bd_q;

    // Forwarding value is final and targets a real register
    assign bus.wd_rdy   = valid_q && (tnew_q == '0) && (a3_q != '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for pipe_stage_reg. Two instances
// (KEEP_PC=1 and KEEP_PC=0) see identical stimulus; a reference model
// predicts each slot, a negedge monitor pops and compares.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic        valid;
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] rt;
        logic [31:0] ao;
        logic [31:0] md;
        logic [31:0] wd;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic [2:0]  tnew;
        logic [4:0]  exc;
        logic        bd;
        logic        rdy;
    } st_t;

    typedef struct packed {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        valid;
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] rt;
        logic [31:0] ao;
        logic [31:0] md;
        logic [4:0]  a2;
        logic [4:0]  a3;
        logic [2:0]  tnew;
        logic [1:0]  wdsel;
        logic [4:0]  exc;
        logic        bd;
        logic        exc_new;
        logic [4:0]  exc_code_new;
    } in_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    st_t  q1[$];
    st_t  q0[$];
    st_t  m1;
    st_t  m0;

    pipe_stage_reg_if #(.DW(32), .RW(5), .TW(3), .EW(5)) b1 ();
    pipe_stage_reg_if #(.DW(32), .RW(5), .TW(3), .EW(5)) b0 ();

    pipe_stage_reg #(.DW(32), .RW(5), .TW(3), .EW(5), .PC_OFF(8), .KEEP_PC(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(b1)
    );
    pipe_stage_reg #(.DW(32), .RW(5), .TW(3), .EW(5), .PC_OFF(8), .KEEP_PC(1'b0)) dut0 (
        .clk(clk), .rst(rst), .bus(b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what the slot must hold after one rising edge
    function automatic st_t model(input st_t cur, input in_t d, input bit keep);
        st_t n;
        logic [4:0] merged;
        n = '0;
        if (d.rst) begin
            n = '0;
        end else if (d.flush) begin
            if (keep) begin
                n.pc = d.pc;
                n.bd = d.bd;
            end
        end else if (d.stall) begin
            n = cur;
        end else begin
            n.valid = d.valid;
            n.ir    = d.ir;
            n.pc    = d.pc;
            n.rt    = d.rt;
            n.ao    = d.ao;
            n.md    = d.md;
            n.a2    = d.a2;
            n.bd    = d.bd;
            n.a3    = d.a3;
            n.tnew  = (d.tnew > 0) ? 3'(int'(d.tnew) - 1) : 3'd0;
            case (d.wdsel)
                2'd0:    n.wd = d.ao;
                2'd1:    n.wd = d.md;
                2'd2:    n.wd = 32'((64'(d.pc) + 64'd8) % 64'h1_0000_0000);
                default: n.wd = 32'd0;
            endcase
            if (d.exc != 0)          merged = d.exc;
            else if (d.exc_new)      merged = d.exc_code_new;
            else                     merged = 5'd0;
            n.exc = merged;
            if (merged != 0) begin
                n.a3   = 5'd0;
                n.tnew = 3'd0;
                n.wd   = 32'd0;
            end
        end
        n.rdy = n.valid && (n.tnew == 0) && (n.a3 != 0);
        return n;
    endfunction

    task automatic drive_bus(input in_t d);
        rst = d.rst;
        b1.stall = d.stall;        b0.stall = d.stall;
        b1.flush = d.flush;        b0.flush = d.flush;
        b1.valid_i = d.valid;      b0.valid_i = d.valid;
        b1.ir_i = d.ir;            b0.ir_i = d.ir;
        b1.pc_i = d.pc;            b0.pc_i = d.pc;
        b1.rt_i = d.rt;            b0.rt_i = d.rt;
        b1.ao_i = d.ao;            b0.ao_i = d.ao;
        b1.md_i = d.md;            b0.md_i = d.md;
        b1.a2_i = d.a2;            b0.a2_i = d.a2;
        b1.a3_i = d.a3;            b0.a3_i = d.a3;
        b1.tnew_i = d.tnew;        b0.tnew_i = d.tnew;
        b1.wd_sel_i = d.wdsel;     b0.wd_sel_i = d.wdsel;
        b1.exc_code_i = d.exc;     b0.exc_code_i = d.exc;
        b1.bd_i = d.bd;            b0.bd_i = d.bd;
        b1.exc_new_i = d.exc_new;  b0.exc_new_i = d.exc_new;
        b1.exc_code_new_i = d.exc_code_new;
        b0.exc_code_new_i = d.exc_code_new;
    endtask

    // Drive one slot, predict both instances, push after the edge
    task automatic step(input in_t d);
        st_t n1;
        st_t n0;
        drive_bus(d);
        n1 = model(m1, d, 1'b1);
        n0 = model(m0, d, 1'b0);
        @(posedge clk);
        m1 = n1;
        m0 = n0;
        q1.push_back(n1);
        q0.push_back(n0);
        #1;
    endtask

    function automatic in_t idle();
        in_t d;
        d = '0;
        return d;
    endfunction

    function automatic in_t rnd();
        in_t d;
        d.rst          = ($urandom_range(0, 49) == 0);
        d.stall        = ($urandom_range(0, 4) == 0);
        d.flush        = ($urandom_range(0, 7) == 0);
        d.valid        = 1'($urandom);
        d.ir           = $urandom;
        d.pc           = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
        d.rt           = $urandom;
        d.ao           = $urandom;
        d.md           = $urandom;
        d.a2           = 5'($urandom);
        d.a3           = 5'($urandom);
        d.tnew         = 3'($urandom);
        d.wdsel        = 2'($urandom);
        d.exc          = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
        d.bd           = 1'($urandom);
        d.exc_new      = ($urandom_range(0, 3) == 0);
        d.exc_code_new = 5'($urandom);
        return d;
    endfunction

    function automatic st_t sample1();
        return {b1.valid, b1.ir, b1.pc, b1.rt, b1.ao, b1.md, b1.wd,
                b1.a2, b1.a3, b1.tnew, b1.exc_code, b1.bd, b1.wd_rdy};
    endfunction

    function automatic st_t sample0();
        return {b0.valid, b0.ir, b0.pc, b0.rt, b0.ao, b0.md, b0.wd,
                b0.a2, b0.a3, b0.tnew, b0.exc_code, b0.bd, b0.wd_rdy};
    endfunction

    // Monitor: the slot is presented every cycle; compare mid-cycle
    always @(negedge clk) begin
        st_t a;
        st_t e;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            a = sample1();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL slot_keep1 t=%0t got=%h want=%h", $time, a, e);
            end
        end
        if (q0.size() > 0) begin
            e = q0.pop_front();
            a = sample0();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL slot_keep0 t=%0t got=%h want=%h", $time, a, e);
            end
        end
    end

    // Direct check against a value fixed by the block's behaviour
    task automatic cchk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    initial begin
        in_t d;
        m1 = '0;
        m0 = '0;

        // reset with busy inputs
        d = rnd();
        d.rst = 1'b1; d.valid = 1'b1; d.a3 = 5'd9; d.pc = 32'h1234_5670;
        step(d);
        cchk("reset_valid", 32'(b1.valid), 32'd0);
        cchk("reset_pc", b1.pc, 32'd0);
        cchk("reset_wd_rdy", 32'(b1.wd_rdy), 32'd0);

        // link address forwarding, tnew countdown
        d = idle();
        d.pc = 32'h3000; d.wdsel = 2'd2; d.tnew = 3'd2; d.a3 = 5'd31; d.valid = 1'b1;
        step(d);
        cchk("load_wd", b1.wd, 32'h3008);
        cchk("load_tnew", 32'(b1.tnew), 32'd1);
        cchk("load_rdy0", 32'(b1.wd_rdy), 32'd0);
        d.tnew = 3'd1;
        step(d);
        cchk("load_tnew0", 32'(b1.tnew), 32'd0);
        cchk("load_rdy1", 32'(b1.wd_rdy), 32'd1);

        // stall holds for three edges
        d = idle();
        d.ao = 32'h1234; d.wdsel = 2'd0; d.tnew = 3'd3; d.a3 = 5'd4; d.valid = 1'b1;
        step(d);
        d.stall = 1'b1; d.ao = 32'hFFFF; d.tnew = 3'd6;
        for (int i = 0; i < 3; i++) step(d);
        cchk("stall_wd", b1.wd, 32'h1234);
        cchk("stall_tnew", 32'(b1.tnew), 32'd2);
        d.stall = 1'b0;
        step(d);
        cchk("release_wd", b1.wd, 32'hFFFF);

        // flush beats stall
        d = rnd();
        d.rst = 1'b0; d.stall = 1'b1; d.flush = 1'b1; d.pc = 32'h3010; d.bd = 1'b1;
        step(d);
        cchk("flush_valid", 32'(b1.valid), 32'd0);
        cchk("flush_pc_keep", b1.pc, 32'h3010);
        cchk("flush_bd_keep", 32'(b1.bd), 32'd1);
        cchk("flush_pc_nokeep", b0.pc, 32'd0);
        cchk("flush_bd_nokeep", 32'(b0.bd), 32'd0);

        // exception merge and writeback suppression
        d = idle();
        d.valid = 1'b1; d.exc = 5'd4; d.exc_new = 1'b1; d.exc_code_new = 5'd12;
        d.a3 = 5'd8; d.tnew = 3'd2; d.ao = 32'hAAAA; d.wdsel = 2'd0;
        step(d);
        cchk("exc_early", 32'(b1.exc_code), 32'd4);
        cchk("exc_a3", 32'(b1.a3), 32'd0);
        cchk("exc_wd", b1.wd, 32'd0);
        d.exc = 5'd0;
        step(d);
        cchk("exc_new", 32'(b1.exc_code), 32'd12);

        // boundaries
        d = idle();
        d.valid = 1'b1; d.a3 = 5'd2; d.tnew = 3'd0;
        step(d);
        cchk("tnew_zero", 32'(b1.tnew), 32'd0);
        d.tnew = 3'd7;
        step(d);
        cchk("tnew_max", 32'(b1.tnew), 32'd6);
        d.pc = 32'hFFFF_FFFC; d.wdsel = 2'd2;
        step(d);
        cchk("pc_wrap", b1.wd, 32'h4);

        // reset in the middle of a flush
        d = rnd();
        d.rst = 1'b1; d.flush = 1'b1; d.pc = 32'h5000;
        step(d);
        cchk("rst_over_flush_pc", b1.pc, 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(rnd());
        end

        // drain the scoreboard
        for (int i = 0; i < 4 && (q1.size() > 0 || q0.size() > 0); i++) @(posedge clk);
        checks++;
        if (q1.size() != 0 || q0.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", q1.size() + q0.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
